sbd_fifo_mw: RTL and testbench
==============================

# sbd_fifo_mw

Parametrised multi-wide in-order scoreboard FIFO; successor to the fixed 2-wide `sbd_fifo_t` queue. Holds one `sbd_fifo_t` entry (pipeline mask + PC) per issued instruction, accepting up to EnqW entries per cycle from issue. Releases up to DeqW head entries per cycle to commit, in program order. Adds flush, occupancy reporting, a pipeline-busy summary and a sticky protocol-error flag.

## Interface
- Depth, 8: entry count; power of two, >= 4, >= max(EnqW, DeqW).
- EnqW, 2: enqueue lanes per cycle, 1..4.
- DeqW, 2: dequeue lanes per cycle, 1..4.
- PlW, 5: width of the one-hot pipeline field `pl`, matching `sbd_fifo_t`.
- clk_i  in  1  clock.
- rst_i  in  1  reset; asynchronous, active-high.
- enq_valid_i  in  EnqW  lane valids; thermometer, lane 0 first.
- enq_data_i  in  EnqW x sbd_fifo_t  lane payloads.
- enq_ready_o  out  1  high when free slots >= EnqW.
- deq_valid_o  out  DeqW  head-entry valids; thermometer.
- deq_data_o  out  DeqW x sbd_fifo_t  head entries; lane 0 is the oldest.
- deq_ack_i  in  DeqW  commit acknowledges; thermometer.
- flush_i  in  1  discard all entries.
- count_o  out  $clog2(Depth+1)  occupancy.
- full_o / empty_o  out  1  count_o==Depth / count_o==0.
- pl_busy_o  out  PlW  OR of `pl` over all valid entries.
- proto_err_o  out  1  sticky protocol violation.

## Operation
- Storage: Depth-entry circular array. rd_ptr and wr_ptr are log2(Depth)+1 bits; the MSB disambiguates full from empty.
- Enqueue:
  - nenq = popcount(enq_valid_i) when enq_ready_o=1, else 0.
  - Lane k is written to slot wr_ptr+k mod Depth.
  - wr_ptr advances by nenq.
- Dequeue:
  - deq_valid_o[k] = (k < count_o).
  - deq_data_o[k] = slot rd_ptr+k mod Depth.
  - ndeq = popcount(deq_ack_i & deq_valid_o); rd_ptr advances by ndeq.
- Counter: count_next = count + nenq - ndeq; wrap is implicit in the pointer arithmetic.
- Simultaneous enq and deq in one cycle are both honoured.
- enq_ready_o is computed from the start-of-cycle count only. Same-cycle dequeues do not free space for enqueue.
- Flush:
  - flush_i=1 sets rd_ptr=wr_ptr=0 and count=0 on the next edge.
  - Any enq/deq in the flush cycle is discarded.
  - proto_err_o is not cleared by flush.
- pl_busy_o: combinational OR over occupied slots. A bit is cleared in the cycle after the last entry carrying that bit is dequeued.
- proto_err_o is set on any of:
  - non-thermometer enq_valid_i;
  - non-thermometer deq_ack_i;
  - deq_ack_i[k] with deq_valid_o[k]=0;
  - enq_valid_i!=0 while enq_ready_o=0.
  
  Offending acks are masked; offending enqueues are dropped. proto_err_o clears only on reset.
- Storage entries are reset to NULL; unoccupied slots are don't-care after use.

## Timing
- Reset values:
  - count_o=0, empty_o=1, full_o=0, enq_ready_o=1 (Depth >= EnqW);
  - deq_valid_o=0, deq_data_o=0, pl_busy_o=0, proto_err_o=0.
- Reset asserted mid-operation clears all state immediately (asynchronously), including pointers and the error flag.
- Enqueue-to-visible latency: an entry enqueued at edge N appears on deq_valid_o/deq_data_o after edge N (1 cycle). No bypass.
- Dequeue takes effect at the edge; the next head is presented in the following cycle.
- All outputs are functions of registered state only. There is no combinational path from any input to any output.
- Full: enq_ready_o=0 whenever Depth-count < EnqW, even if fewer lanes are valid.
- Wrap: slot indices are taken mod Depth. Pointer MSBs toggle on each wrap.

## Structure
- `sbd_fifo_t`, the function `therm_ok()` (thermometer check) and the function `popcnt()` belong in `super_pkg`.
- Sub-module `sbd_lane_cnt`:
  - inputs: a lane mask and its qualifying mask;
  - outputs: masked count, thermometer-ok flag;
  - instantiated once for enqueue and once for dequeue.
- Storage is a flop array; no SRAM macro.

## Test plan
All scenarios use Depth=8, EnqW=2, DeqW=2.
- Reset, then enq 2'b11 {pl=5'b00010, pc=0x100; pl=5'b00100, pc=0x104} -> next cycle deq_valid_o=2'b11, lane0 pc=0x100, count_o=2, pl_busy_o=5'b00110.
- Fill to count 7 -> enq_ready_o=0. Enq 2'b01 that cycle -> proto_err_o=1 next cycle, count stays 7.
- Count 6, enq 2'b11 + ack 2'b11 in the same cycle -> count 6. The 4 writes/reads across the wrap from slot 7 to slot 0 keep PC order.
- Ack 2'b11 when only 1 entry is valid -> one entry dequeued, count 0, empty_o=1, proto_err_o=1.
- Count 5, flush_i=1 with enq 2'b11 -> next cycle count_o=0, empty_o=1, pl_busy_o=0, deq_valid_o=0.
- Assert rst_i asynchronously mid-cycle at count 4 with proto_err_o=1 -> outputs take reset values before the next clock edge.

Source files
------------

// File: rtl/super_pkg.sv
// Shared scoreboard types and lane-mask helpers for the issue/commit queue.
package super_pkg;

  localparam int unsigned PL_W     = 5;
  localparam int unsigned PC_W     = 32;
  localparam int unsigned LANE_MAX = 4;

  typedef struct packed {
    logic [PL_W-1:0] pl;
    logic [PC_W-1:0] pc;
  } sbd_fifo_t;

  localparam sbd_fifo_t SBD_NULL = '0;

  // True when set bits form a contiguous run starting at lane 0 (zero counts).
  function automatic logic therm_ok(input logic [LANE_MAX-1:0] v);
    return (v & (v + LANE_MAX'(1))) == '0;
  endfunction

  function automatic logic [2:0] popcnt(input logic [LANE_MAX-1:0] v);
    logic [2:0] n;
    n = '0;
    for (int i = 0; i < int'(LANE_MAX); i++) n = n + 3'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/sbd_fifo_mw_lane_cnt.sv
// Counts qualified lanes of a request mask and flags non-thermometer masks.
module sbd_lane_cnt
  import super_pkg::*;
#(
  parameter int unsigned W = 2
) (
  input  logic [W-1:0]             lane_i,
  input  logic [W-1:0]             qual_i,
  output logic [$clog2(W+1)-1:0]   cnt_c,
  output logic                     therm_ok_c
);

  localparam int unsigned CW = $clog2(W + 1);

  logic [LANE_MAX-1:0] lane_x;
  logic [LANE_MAX-1:0] qual_x;

  assign lane_x     = LANE_MAX'(lane_i);
  assign qual_x     = LANE_MAX'(qual_i);
  assign cnt_c      = CW'(popcnt(lane_x & qual_x));
  assign therm_ok_c = therm_ok(lane_x);

endmodule

// File: rtl/sbd_fifo_mw.sv
// Multi-wide in-order scoreboard FIFO: EnqW lanes in from issue, DeqW head
// entries out to commit, with flush, occupancy, pipeline-busy and sticky error.
module sbd_fifo_mw
  import super_pkg::*;
#(
  parameter int unsigned Depth = 8,
  parameter int unsigned EnqW  = 2,
  parameter int unsigned DeqW  = 2,
  parameter int unsigned PlW   = 5
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [EnqW-1:0]              enq_valid_i,
  input  sbd_fifo_t [EnqW-1:0]         enq_data_i,
  output logic                         enq_ready_o,
  output logic [DeqW-1:0]              deq_valid_o,
  output sbd_fifo_t [DeqW-1:0]         deq_data_o,
  input  logic [DeqW-1:0]              deq_ack_i,
  input  logic                         flush_i,
  output logic [$clog2(Depth+1)-1:0]   count_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [PlW-1:0]               pl_busy_o,
  output logic                         proto_err_o
);

  localparam int unsigned AW = $clog2(Depth);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned CW = $clog2(Depth + 1);
  localparam int unsigned EW = $clog2(EnqW + 1);
  localparam int unsigned DW = $clog2(DeqW + 1);

  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  sbd_fifo_t     mem_q [Depth];
  sbd_fifo_t     mem_d [Depth];
  logic          err_q, err_d;

  logic [EW-1:0] enq_cnt_c, nenq;
  logic [DW-1:0] deq_cnt_c, ndeq;
  logic          enq_therm_c, deq_therm_c;
  logic [PlW-1:0] busy;

  // Every output below depends on registered state only.
  assign count_o     = CW'(wr_ptr_q - rd_ptr_q);
  assign full_o      = count_o == CW'(Depth);
  assign empty_o     = count_o == '0;
  assign enq_ready_o = (CW'(Depth) - count_o) >= CW'(EnqW);
  assign proto_err_o = err_q;
  assign pl_busy_o   = busy;

  always_comb begin
    for (int k = 0; k < int'(DeqW); k++) begin
      deq_valid_o[k] = CW'(k) < count_o;
      deq_data_o[k]  = mem_q[AW'(rd_ptr_q + PW'(k))];
    end
  end

  always_comb begin
    busy = '0;
    for (int i = 0; i < int'(Depth); i++) begin
      if (CW'(i) < count_o) busy = busy | PlW'(mem_q[AW'(rd_ptr_q + PW'(i))].pl);
    end
  end

  sbd_lane_cnt #(.W(EnqW)) u_enq_cnt (
    .lane_i     (enq_valid_i),
    .qual_i     ({EnqW{enq_ready_o}}),
    .cnt_c      (enq_cnt_c),
    .therm_ok_c (enq_therm_c)
  );

  sbd_lane_cnt #(.W(DeqW)) u_deq_cnt (
    .lane_i     (deq_ack_i),
    .qual_i     (deq_valid_o),
    .cnt_c      (deq_cnt_c),
    .therm_ok_c (deq_therm_c)
  );

  // Malformed masks are dropped whole rather than partially honoured.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    mem_d    = mem_q;
    err_d    = err_q;
    nenq     = enq_therm_c ? enq_cnt_c : '0;
    ndeq     = deq_therm_c ? deq_cnt_c : '0;

    if (!enq_therm_c || !deq_therm_c || (|(deq_ack_i & ~deq_valid_o)) ||
        (|enq_valid_i && !enq_ready_o)) begin
      err_d = 1'b1;
    end

    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      for (int k = 0; k < int'(EnqW); k++) begin
        if (PW'(k) < PW'(nenq)) mem_d[AW'(wr_ptr_q + PW'(k))] = enq_data_i[k];
      end
      wr_ptr_d = wr_ptr_q + PW'(nenq);
      rd_ptr_d = rd_ptr_q + PW'(ndeq);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      err_q    <= 1'b0;
      for (int i = 0; i < int'(Depth); i++) mem_q[i] <= SBD_NULL;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      err_q    <= err_d;
      for (int i = 0; i < int'(Depth); i++) mem_q[i] <= mem_d[i];
    end
  end

endmodule

// File: tb/tb_sbd_fifo_mw.sv
// Self-checking bench for sbd_fifo_mw (Depth=8, EnqW=2, DeqW=2).
module tb_sbd_fifo_mw;
  import super_pkg::*;

  logic            clk = 1'b0;
  logic            rst;
  logic [1:0]      enq_valid;
  sbd_fifo_t [1:0] enq_data;
  logic            enq_ready;
  logic [1:0]      deq_valid;
  sbd_fifo_t [1:0] deq_data;
  logic [1:0]      deq_ack;
  logic            flush;
  logic [3:0]      count;
  logic            full;
  logic            empty;
  logic [4:0]      pl_busy;
  logic            proto_err;

  int checks = 0;
  int errors = 0;

  sbd_fifo_t   sb[$];
  logic        m_err;
  logic [31:0] next_pc;

  typedef struct {
    logic [1:0] enq;
    logic [1:0] ack;
    logic       flush;
    int         exp_cnt;
    logic       exp_err;
  } vec_t;

  vec_t vecs[23];

  always #5 clk = ~clk;

  sbd_fifo_mw #(.Depth(8), .EnqW(2), .DeqW(2), .PlW(5)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .enq_valid_i (enq_valid),
    .enq_data_i  (enq_data),
    .enq_ready_o (enq_ready),
    .deq_valid_o (deq_valid),
    .deq_data_o  (deq_data),
    .deq_ack_i   (deq_ack),
    .flush_i     (flush),
    .count_o     (count),
    .full_o      (full),
    .empty_o     (empty),
    .pl_busy_o   (pl_busy),
    .proto_err_o (proto_err)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic sbd_fifo_t mk(input logic [31:0] pc);
    sbd_fifo_t e;
    int idx;
    idx  = (int'((pc - 32'h100) >> 2) + 1) % 5;
    e.pl = 5'(1) << idx;
    e.pc = pc;
    return e;
  endfunction

  function automatic logic therm2(input logic [1:0] v);
    return v != 2'b10;
  endfunction

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_count"}, 64'(count), 64'(0));
    chk({tag, "_empty"}, 64'(empty), 64'(1));
    chk({tag, "_full"}, 64'(full), 64'(0));
    chk({tag, "_ready"}, 64'(enq_ready), 64'(1));
    chk({tag, "_deq_valid"}, 64'(deq_valid), 64'(0));
    chk({tag, "_deq_data0"}, 64'(deq_data[0]), 64'(0));
    chk({tag, "_deq_data1"}, 64'(deq_data[1]), 64'(0));
    chk({tag, "_pl_busy"}, 64'(pl_busy), 64'(0));
    chk({tag, "_proto_err"}, 64'(proto_err), 64'(0));
  endtask

  // Drive one cycle; compare pre-edge outputs to the model, pop on ack, push on enqueue.
  task automatic step(input logic [1:0] enq, input logic [1:0] ack, input logic fl);
    int         cnt;
    logic       rdy;
    logic [1:0] vm;
    logic [4:0] busy;
    sbd_fifo_t  e;
    enq_valid   = enq;
    enq_data[0] = mk(next_pc);
    enq_data[1] = mk(next_pc + 32'd4);
    deq_ack     = ack;
    flush       = fl;
    #3;
    cnt  = sb.size();
    rdy  = (8 - cnt) >= 2;
    vm   = (cnt >= 2) ? 2'b11 : ((cnt == 1) ? 2'b01 : 2'b00);
    busy = '0;
    foreach (sb[i]) busy = busy | sb[i].pl;
    chk("count", 64'(count), 64'(cnt));
    chk("enq_ready", 64'(enq_ready), 64'(rdy));
    chk("deq_valid", 64'(deq_valid), 64'(vm));
    chk("pl_busy", 64'(pl_busy), 64'(busy));
    chk("full", 64'(full), 64'(cnt == 8));
    chk("empty", 64'(empty), 64'(cnt == 0));
    chk("proto_err", 64'(proto_err), 64'(m_err));
    if (!therm2(enq) || !therm2(ack) || ((ack & ~vm) != 2'b00) || (enq != 2'b00 && !rdy))
      m_err = 1'b1;
    if (fl) begin
      sb.delete();
    end else begin
      if (therm2(ack)) begin
        for (int k = 0; k < 2; k++) begin
          if (ack[k] && vm[k]) begin
            e = sb.pop_front();
            chk($sformatf("deq_data%0d", k), 64'(deq_data[k]), 64'(e));
          end
        end
      end
      if (rdy && therm2(enq)) begin
        for (int k = 0; k < 2; k++) begin
          if (enq[k]) begin
            sb.push_back(enq_data[k]);
            next_pc = next_pc + 32'd4;
          end
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input int i);
    step(vecs[i].enq, vecs[i].ack, vecs[i].flush);
    chk($sformatf("vec%0d_count", i), 64'(count), 64'(vecs[i].exp_cnt));
    chk($sformatf("vec%0d_err", i), 64'(proto_err), 64'(vecs[i].exp_err));
    if (vecs[i].flush) begin
      chk($sformatf("vec%0d_flush_empty", i), 64'(empty), 64'(1));
      chk($sformatf("vec%0d_flush_busy", i), 64'(pl_busy), 64'(0));
      chk($sformatf("vec%0d_flush_valid", i), 64'(deq_valid), 64'(0));
    end
  endtask

  initial begin
    // Phase 1: fill, wrap with simultaneous enq/deq, drain, over-ack.
    vecs[0]  = '{2'b11, 2'b00, 1'b0, 4, 1'b0};
    vecs[1]  = '{2'b11, 2'b00, 1'b0, 6, 1'b0};
    vecs[2]  = '{2'b01, 2'b00, 1'b0, 7, 1'b0};
    vecs[3]  = '{2'b00, 2'b01, 1'b0, 6, 1'b0};
    vecs[4]  = '{2'b11, 2'b11, 1'b0, 6, 1'b0};
    vecs[5]  = '{2'b00, 2'b11, 1'b0, 4, 1'b0};
    vecs[6]  = '{2'b00, 2'b11, 1'b0, 2, 1'b0};
    vecs[7]  = '{2'b00, 2'b11, 1'b0, 0, 1'b0};
    vecs[8]  = '{2'b01, 2'b00, 1'b0, 1, 1'b0};
    vecs[9]  = '{2'b00, 2'b11, 1'b0, 0, 1'b1};
    vecs[10] = '{2'b11, 2'b00, 1'b0, 2, 1'b1};
    vecs[11] = '{2'b11, 2'b00, 1'b0, 4, 1'b1};
    // Phase 2 (after async reset): full-drop, flush, malformed masks.
    vecs[12] = '{2'b11, 2'b00, 1'b0, 2, 1'b0};
    vecs[13] = '{2'b11, 2'b00, 1'b0, 4, 1'b0};
    vecs[14] = '{2'b11, 2'b00, 1'b0, 6, 1'b0};
    vecs[15] = '{2'b01, 2'b00, 1'b0, 7, 1'b0};
    vecs[16] = '{2'b01, 2'b00, 1'b0, 7, 1'b1};
    vecs[17] = '{2'b00, 2'b11, 1'b0, 5, 1'b1};
    vecs[18] = '{2'b11, 2'b00, 1'b1, 0, 1'b1};
    vecs[19] = '{2'b11, 2'b00, 1'b0, 2, 1'b1};
    vecs[20] = '{2'b10, 2'b00, 1'b0, 2, 1'b1};
    vecs[21] = '{2'b00, 2'b10, 1'b0, 2, 1'b1};
    vecs[22] = '{2'b00, 2'b11, 1'b0, 0, 1'b1};

    rst       = 1'b1;
    enq_valid = '0;
    enq_data  = '0;
    deq_ack   = '0;
    flush     = 1'b0;
    next_pc   = 32'h100;
    m_err     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals("rst");
    rst = 1'b0;

    step(2'b11, 2'b00, 1'b0);
    chk("first_valid", 64'(deq_valid), 64'(2'b11));
    chk("first_pc", 64'(deq_data[0].pc), 64'(32'h100));
    chk("first_count", 64'(count), 64'(2));
    chk("first_busy", 64'(pl_busy), 64'(5'b00110));

    for (int i = 0; i < 12; i++) run_vec(i);

    // Asynchronous reset between clock edges at count 4 with the error flag set.
    enq_valid = '0;
    deq_ack   = '0;
    flush     = 1'b0;
    chk("pre_arst_count", 64'(count), 64'(4));
    chk("pre_arst_err", 64'(proto_err), 64'(1));
    #2 rst = 1'b1;
    #1 chk_reset_vals("arst");
    #2 rst = 1'b0;
    sb.delete();
    m_err = 1'b0;
    @(posedge clk);
    #1;
    chk("post_arst_count", 64'(count), 64'(0));

    for (int i = 12; i < 23; i++) run_vec(i);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
